fir_ctrl: RTL
=============

FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 The block SHALL have parameter PIPE_LAT, default 2, giving the MAC pipeline drain depth in cycles, legal range 0..15.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset that is asynchronous and active-high.
REQ-004 The block SHALL have port input_valid, input, 1 bit, meaning a new sample is present on the datapath input.
REQ-005 The block SHALL have port co, input, 1 bit, the carry-out of the external tap-index counter, high when that counter is at all-ones and enabled.
REQ-006 The block SHALL have port ready, output, 1 bit, meaning the block accepts a sample this cycle.
REQ-007 The block SHALL have port shift_en, output, 1 bit, the sample delay-line shift strobe.
REQ-008 The block SHALL have port cnt_clr, output, 1 bit, the synchronous clear of the external tap counter.
REQ-009 The block SHALL have port cnt_en, output, 1 bit, the increment enable of the external tap counter.
REQ-010 The block SHALL have port acc_clr, output, 1 bit, the accumulator clear.
REQ-011 The block SHALL have port acc_en, output, 1 bit, the MAC accumulate enable.
REQ-012 The block SHALL have port output_valid, output, 1 bit, a one-cycle strobe marking the filter output as valid.

Function
REQ-013 The block SHALL implement a Moore FSM with states IDLE, LOAD, CALC, DRAIN and DONE; all outputs SHALL decode from the state only and SHALL be glitch-free registered-state decodes.
REQ-014 In IDLE, ready SHALL be 1 and all other outputs SHALL be 0; input_valid=1 sampled SHALL move the FSM to LOAD, otherwise the FSM SHALL stay in IDLE.
REQ-015 LOAD SHALL last exactly 1 cycle with shift_en=1, cnt_clr=1 and acc_clr=1, and the FSM SHALL then move to CALC.
REQ-016 In CALC, cnt_en=1 and acc_en=1; co=1 sampled SHALL move the FSM to DRAIN if PIPE_LAT>0, else to DONE; co=0 SHALL keep the FSM in CALC.
REQ-017 In DRAIN, an internal 4-bit drain counter, cleared on entry, SHALL increment each cycle; the FSM SHALL move to DONE when the counter reaches PIPE_LAT-1, giving exactly PIPE_LAT DRAIN cycles.
REQ-018 DONE SHALL last exactly 1 cycle with output_valid=1, and the FSM SHALL then return to IDLE.
REQ-019 input_valid outside IDLE SHALL be ignored, with no queuing and no effect on the current computation.
REQ-020 co outside CALC SHALL be ignored.
REQ-021 ready, cnt_en and cnt_clr SHALL never be 1 in the same cycle.
REQ-022 input_valid=1 held continuously SHALL start a new computation from the IDLE cycle that follows DONE, with one ready cycle between consecutive computations.
REQ-023 With a W-bit tap counter, the latency from input_valid sampled to output_valid SHALL be 2^W + PIPE_LAT + 2 cycles.

Reset
REQ-024 rst=1 SHALL force the FSM to IDLE and the drain counter to 0 immediately, without waiting for a clock edge.
REQ-025 While rst=1, outputs SHALL be ready=1 and every other output 0.
REQ-026 rst asserted mid-operation (LOAD, CALC, DRAIN or DONE) SHALL abort the computation with no output_valid pulse.
REQ-027 After rst deasserts, the first rising edge SHALL evaluate IDLE normally.

Verification
REQ-028 The bench SHALL check reset: rst=1 for 12 ns with clock period 10 ns -> ready=1 and all other outputs 0 both during and after reset.
REQ-029 The bench SHALL check a single sample: 3-bit counter model, PIPE_LAT=2, input_valid pulsed in IDLE at edge 0 -> LOAD at cycle 1, CALC for cycles 2-9, DRAIN for cycles 10-11, output_valid at cycle 12 only, ready again at cycle 13.
REQ-030 The bench SHALL check PIPE_LAT=0: same stimulus as REQ-029 -> output_valid at cycle 10 and no DRAIN state entered.
REQ-031 The bench SHALL check back-to-back operation: input_valid held high for 40 cycles -> output_valid pulses exactly 13 cycles apart, with no shift_en while the FSM is not in LOAD.
REQ-032 The bench SHALL check abort: rst pulsed for 3 ns while in CALC (cycle 5 of REQ-029) -> FSM immediately in IDLE, no output_valid; a following input_valid gives nominal latency.
REQ-033 The bench SHALL check stray co: co forced to 1 during IDLE and DRAIN -> no state change and DRAIN length unchanged.

Source files
------------

// File: rtl/fir_ctrl_if.sv
// Handshake and control bundle between the FIR sequencer and its datapath.
// The datapath side (master) presents samples and the tap-counter carry;
// the sequencer side (slave) returns the strobes that steer the datapath.
interface fir_ctrl_if;
  logic input_valid;
  logic co;
  logic ready;
  logic shift_en;
  logic cnt_clr;
  logic cnt_en;
  logic acc_clr;
  logic acc_en;
  logic output_valid;

  modport master (
    output input_valid,
    output co,
    input  ready,
    input  shift_en,
    input  cnt_clr,
    input  cnt_en,
    input  acc_clr,
    input  acc_en,
    input  output_valid
  );

  modport slave (
    input  input_valid,
    input  co,
    output ready,
    output shift_en,
    output cnt_clr,
    output cnt_en,
    output acc_clr,
    output acc_en,
    output output_valid
  );
endinterface

// File: rtl/fir_ctrl.sv
// FIR filter sequencer: a Moore FSM that loads one sample, walks the
// external tap counter through every coefficient while the MAC accumulates,
// waits out the MAC pipeline, then strobes the result as valid.
// States are one-hot so every output is a single flop bit and cannot glitch.
module fir_ctrl #(
  parameter int PIPE_LAT = 2
) (
  input  logic      clk,
  input  logic      rst,
  fir_ctrl_if.slave bus
);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    LOAD  = 5'b00010,
    CALC  = 5'b00100,
    DRAIN = 5'b01000,
    DONE  = 5'b10000
  } state_t;

  // Last drain-counter value before leaving DRAIN; unused when PIPE_LAT is 0.
  localparam logic [3:0] DRAIN_LAST = (PIPE_LAT > 0) ? 4'(PIPE_LAT - 1) : 4'd0;

  state_t     state;
  state_t     state_next;
  logic [3:0] drain_cnt;

  // State register; reset drops straight back to IDLE without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Drain counter is held at zero outside DRAIN so it starts from zero on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt <= 4'd0;
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt + 4'd1;
    end else begin
      drain_cnt <= 4'd0;
    end
  end

  // Next-state logic; input_valid only matters in IDLE and co only in CALC.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.input_valid) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = CALC;
      end
      CALC: begin
        if (bus.co) begin
          state_next = (PIPE_LAT > 0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode: each strobe is a single state bit of the one-hot register.
  always_comb begin
    bus.ready        = state[0];
    bus.shift_en     = state[1];
    bus.cnt_clr      = state[1];
    bus.acc_clr      = state[1];
    bus.cnt_en       = state[2];
    bus.acc_en       = state[2];
    bus.output_valid = state[4];
  end

endmodule
